// File: rtl/fmap_pkg.sv
// Shared types and constants for the conv-output / feature-map collection path.
package fmap_pkg;

    localparam int ACC_W_DEF = 32;

    typedef logic signed [7:0]           pixel_t;
    typedef logic signed [ACC_W_DEF-1:0] acc_t;

    localparam pixel_t PIX_MAX = 8'sh7f;
    localparam pixel_t PIX_MIN = 8'sh80;

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

endpackage

// File: rtl/requant_relu_sat.sv
// Combinational requantizer: round-half-up arithmetic shift, optional ReLU,
// then saturation to a signed 8-bit pixel.
module requant_relu_sat
    import fmap_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int SHIFT   = 8,
    parameter bit RELU_EN = 1'b1
) (
    input  logic signed [ACC_W-1:0] in_acc,
    output pixel_t                  pix
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam logic signed [ACC_W:0] ROUND = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_W:0] T_MAX = (ACC_W + 1)'(PIX_MAX);
    localparam logic signed [ACC_W:0] T_MIN = (ACC_W + 1)'(PIX_MIN);

    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] t;

    // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
    always_comb begin
        sum = {in_acc[ACC_W-1], in_acc} + ROUND;
        t   = sum >>> SHIFT;
        if (RELU_EN && t[ACC_W]) begin
            t = '0;
        end
        if (t > T_MAX) begin
            pix = PIX_MAX;
        end else if (t < T_MIN) begin
            pix = PIX_MIN;
        end else begin
            pix = t[7:0];
        end
    end

endmodule

// File: rtl/fmap_frame_collector.sv
// Collects a raster stream of conv accumulators into a requantized int8 map
// and holds it for the pooling stage until it is consumed.
module fmap_frame_collector
    import fmap_pkg::*;
#(
    parameter int MAP_SIZE = 24,
    parameter int ACC_W    = 32,
    parameter int SHIFT    = 8,
    parameter bit RELU_EN  = 1'b1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic signed [ACC_W-1:0]                in_acc,
    input  logic                                   in_last,
    output pixel_t [MAP_SIZE-1:0][MAP_SIZE-1:0]    feature_map,
    output logic                                   map_valid,
    input  logic                                   map_ready,
    output logic                                   frame_err
);

    localparam int             CW   = (MAP_SIZE > 2) ? $clog2(MAP_SIZE) : 1;
    localparam logic [CW-1:0]  LAST = CW'(MAP_SIZE - 1);

    state_t        state;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    pixel_t        pix;
    logic          at_last;
    logic          accept;

    requant_relu_sat #(
        .ACC_W   (ACC_W),
        .SHIFT   (SHIFT),
        .RELU_EN (RELU_EN)
    ) u_requant (
        .in_acc (in_acc),
        .pix    (pix)
    );

    assign at_last = (row == LAST) && (col == LAST);
    assign accept  = (state == FILL) && in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            row         <= '0;
            col         <= '0;
            in_ready    <= 1'b1;
            map_valid   <= 1'b0;
            frame_err   <= 1'b0;
            // NOTE: the map storage is reset too, since a reset must present an all-zero map.
            feature_map <= '0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        feature_map[row][col] <= pix;
                        // Framing follows position; in_last is only cross-checked.
                        frame_err <= (in_last != at_last);
                        if (at_last) begin
                            state     <= HOLD;
                            row       <= '0;
                            col       <= '0;
                            in_ready  <= 1'b0;
                            map_valid <= 1'b1;
                        end else if (col == LAST) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (map_valid && map_ready) begin
                        state     <= FILL;
                        in_ready  <= 1'b1;
                        map_valid <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: doc/fmap_frame_collector.md
Name: fmap_frame_collector

Overview:
- Upstream neighbour of the parallel 2x2 max-pool layer.
- Accepts the conv engine's raster-ordered accumulator stream over a valid/ready handshake.
- Requantizes each beat to int8, with optional ReLU, and assembles a full MAP_SIZE x MAP_SIZE signed 8-bit feature map.
- Presents the complete map, held stable, with a valid/ready frame handshake to the pooling stage.

Parameters:
- MAP_SIZE, 24, feature-map height and width in pixels; must be even, >= 2.
- ACC_W, 32, signed accumulator width of input beats.
- SHIFT, 8, requantization right-shift amount; range 1..ACC_W-1.
- RELU_EN, 1, 1 = clamp negative results to 0 before saturation.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  collector can accept a beat.
- in_acc  in  ACC_W signed  conv accumulator for the current raster position.
- in_last  in  1  upstream marks the final pixel of a frame.
- feature_map  out  [MAP_SIZE-1:0][MAP_SIZE-1:0] x 8 signed  assembled map, indexed [row][col].
- map_valid  out  1  feature_map is complete and stable.
- map_ready  in  1  downstream consumed the map.
- frame_err  out  1  one-cycle pulse on an in_last mismatch.

Behaviour:
- Reset (async assert, sync-safe release):
  - state=FILL, row=col=0.
  - in_ready=1, map_valid=0, frame_err=0.
  - All feature_map entries = 0.
- States: FILL, HOLD.
- FILL:
  - in_ready=1, map_valid=0.
  - Beat accepted when in_valid && in_ready; the requantized value is written to feature_map[row][col] at that edge.
  - col increments; at MAP_SIZE-1, col wraps to 0 and row increments.
  - Accepting the beat at (MAP_SIZE-1, MAP_SIZE-1): state goes to HOLD and row/col go to 0.
  - map_valid rises the cycle after the final accepted beat (1-cycle latency).
- HOLD:
  - in_ready=0, map_valid=1.
  - feature_map must not change.
  - On map_valid && map_ready: state goes to FILL at that edge, map_valid=0 and in_ready=1 the next cycle.
  - A beat presented in the handshake cycle is not accepted; it is taken at the earliest in the following cycle.
- Stalls: in_valid low in FILL leaves counters and map unchanged. There is no timeout.
- Requant, per beat, with arithmetic in ACC_W+1 bits so nothing overflows:
  - t = (in_acc + (1 << (SHIFT-1))) >>> SHIFT (round half up, arithmetic shift).
  - If RELU_EN and t < 0, then t = 0.
  - Saturate t to [-128, 127].
- Framing is position-driven; in_last never alters counters or state.
- frame_err pulses high for one cycle after an accepted beat where in_last disagrees with (row==MAP_SIZE-1 && col==MAP_SIZE-1). This covers both an early in_last and a missing in_last.
- After release, feature_map keeps stale contents until overwritten. It is defined only while map_valid=1.
- Reset mid-fill or mid-hold discards the partial or held frame and returns to the reset values.
- No combinational path from map_ready to in_ready; in_ready is a registered function of state.

Decomposition:
- Package fmap_pkg:
  - pixel_t (logic signed [7:0]).
  - acc_t (logic signed [ACC_W-1:0]).
  - PIX_MAX=127, PIX_MIN=-128.
  - State enum (FILL, HOLD).
- Sub-module requant_relu_sat: purely combinational; in_acc in, pixel_t out; parameters SHIFT and RELU_EN. Reusable by other conv-output paths.

Test Plan:
- Reset then stream 576 beats, in_acc = (r*24+c)<<8, in_last on the final beat only:
  - map_valid rises exactly 1 cycle after beat 576.
  - feature_map[r][c] = min(r*24+c, 127).
  - frame_err never pulses.
- Requant corners, SHIFT=8, RELU_EN=1:
  - 0x7F → 0 (0x7F+0x80 = 0xFF, >>>8 = 0).
  - 0x80 → 1 (round half up).
  - 200<<8 → 127 (saturate).
  - -5<<8 → 0 (ReLU).
  - With RELU_EN=0: -300<<8 → -128.
- Full frame held with map_ready=0 for 50 cycles while in_valid=1:
  - in_ready=0 throughout; feature_map unchanged.
  - Assert map_ready: map_valid drops next cycle, and the next beat is written to [0][0].
- Random in_valid gaps (~40%) over a full frame: the map matches the gap-free result and map_valid timing tracks the final accepted beat.
- in_last asserted on beat 100 and absent on beat 576:
  - frame_err pulses twice.
  - The frame still completes after beat 576.
- rst_n low at beat 300:
  - map_valid=0, in_ready=1, feature_map all 0.
  - The next beat lands in [0][0].
